// File: rtl/filter_package.sv
// RX CTLE settings shared by the link emulator and its control logic.
package filter_package;

    localparam int RX_SETTING_WIDTH = 4;

endpackage

// File: rtl/sweep_package.sv
// Shared types and defaults for the TX/RX settings sweep controller.
package sweep_package;

    import tx_package::*;
    import filter_package::*;

    localparam int DEFAULT_CNT_WIDTH = 32;
    localparam int DEFAULT_ERR_WIDTH = 32;

    // Result counts are carried at this width, so ERR_WIDTH may be at most 64.
    localparam int RES_COUNT_WIDTH = 64;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RESET,
        S_SETTLE,
        S_MEASURE,
        S_REPORT
    } sweep_state_t;

    typedef struct packed {
        logic [TX_SETTING_WIDTH-1:0] tx;
        logic [RX_SETTING_WIDTH-1:0] rx;
        logic [RES_COUNT_WIDTH-1:0]  bits;
        logic [RES_COUNT_WIDTH-1:0]  errs;
    } sweep_result_t;

endpackage

// File: rtl/tx_package.sv
// TX FFE settings shared by the link emulator and its control logic.
package tx_package;

    localparam int TX_SETTING_WIDTH = 5;

endpackage

// File: rtl/sat_err_counter.sv
// Saturating checked-bit and bit-error accumulator with synchronous clear.
module sat_err_counter #(
    parameter int ERR_WIDTH = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 clr_i,
    input  logic                 en_i,
    input  logic                 bit_valid_i,
    input  logic                 bit_err_i,
    output logic [ERR_WIDTH-1:0] bits_o,
    output logic [ERR_WIDTH-1:0] errs_o
);

    logic [ERR_WIDTH-1:0] bits_q;
    logic [ERR_WIDTH-1:0] errs_q;

    // Both counters stick at all-ones so a long window never reports a wrapped count.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            bits_q <= '0;
            errs_q <= '0;
        end else if (clr_i) begin
            bits_q <= '0;
            errs_q <= '0;
        end else if (en_i && bit_valid_i) begin
            if (bits_q != '1) begin
                bits_q <= bits_q + 1'b1;
            end
            if (bit_err_i && (errs_q != '1)) begin
                errs_q <= errs_q + 1'b1;
            end
        end
    end

    assign bits_o = bits_q;
    assign errs_o = errs_q;

endmodule

// File: rtl/link_sweep_ctrl.sv
// Steps TX FFE / RX CTLE settings over a grid, measuring bit errors at each point
// and reporting each point's result on a valid/ready channel.
module link_sweep_ctrl
    import tx_package::*;
    import filter_package::*;
    import sweep_package::*;
#(
    parameter int RST_CYCLES = 16,
    parameter int CNT_WIDTH  = DEFAULT_CNT_WIDTH,
    parameter int ERR_WIDTH  = DEFAULT_ERR_WIDTH
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic                        abort,
    input  logic [TX_SETTING_WIDTH-1:0] tx_min,
    input  logic [TX_SETTING_WIDTH-1:0] tx_max,
    input  logic [RX_SETTING_WIDTH-1:0] rx_min,
    input  logic [RX_SETTING_WIDTH-1:0] rx_max,
    input  logic [CNT_WIDTH-1:0]        settle_cycles,
    input  logic [CNT_WIDTH-1:0]        meas_cycles,
    input  logic                        bit_valid,
    input  logic                        bit_err,
    input  logic                        res_ready,
    output logic [TX_SETTING_WIDTH-1:0] tx_setting,
    output logic [RX_SETTING_WIDTH-1:0] rx_setting,
    output logic                        emu_rst,
    output logic                        meas_en,
    output logic                        res_valid,
    output logic [TX_SETTING_WIDTH-1:0] res_tx,
    output logic [RX_SETTING_WIDTH-1:0] res_rx,
    output logic [ERR_WIDTH-1:0]        res_bits,
    output logic [ERR_WIDTH-1:0]        res_errs,
    output logic                        busy,
    output logic                        done,
    output logic                        cfg_err
);

    localparam logic [CNT_WIDTH-1:0] RST_LAST = CNT_WIDTH'(RST_CYCLES - 1);

    sweep_state_t                state_q;
    logic [TX_SETTING_WIDTH-1:0] tx_min_q, tx_max_q, tx_setting_q;
    logic [RX_SETTING_WIDTH-1:0] rx_min_q, rx_max_q, rx_setting_q;
    logic [CNT_WIDTH-1:0]        settle_q, meas_last_q, cnt_q;
    logic                        emu_rst_q, meas_en_q, res_valid_q;
    logic                        busy_q, done_q, cfg_err_q;
    logic                        bad_bounds;
    logic [ERR_WIDTH-1:0]        acc_bits, acc_errs;
    sweep_result_t               result;

    assign bad_bounds = (tx_min > tx_max) || (rx_min > rx_max);

    // cnt_q times every phase and restarts from zero on each state change.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            tx_min_q     <= '0;
            tx_max_q     <= '0;
            tx_setting_q <= '0;
            rx_min_q     <= '0;
            rx_max_q     <= '0;
            rx_setting_q <= '0;
            settle_q     <= '0;
            meas_last_q  <= '0;
            cnt_q        <= '0;
            emu_rst_q    <= 1'b1;
            meas_en_q    <= 1'b0;
            res_valid_q  <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            cfg_err_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (abort) begin
                state_q     <= S_IDLE;
                emu_rst_q   <= 1'b1;
                meas_en_q   <= 1'b0;
                res_valid_q <= 1'b0;
                busy_q      <= 1'b0;
                cnt_q       <= '0;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (start) begin
                            tx_min_q    <= tx_min;
                            tx_max_q    <= tx_max;
                            rx_min_q    <= rx_min;
                            rx_max_q    <= rx_max;
                            settle_q    <= settle_cycles;
                            meas_last_q <= (meas_cycles == '0) ? '0 : meas_cycles - 1'b1;
                            cfg_err_q   <= bad_bounds;
                            if (!bad_bounds) begin
                                tx_setting_q <= tx_min;
                                rx_setting_q <= rx_min;
                                cnt_q        <= '0;
                                busy_q       <= 1'b1;
                                state_q      <= S_RESET;
                            end
                        end
                    end
                    S_RESET: begin
                        if (cnt_q == RST_LAST) begin
                            cnt_q     <= '0;
                            emu_rst_q <= 1'b0;
                            if (settle_q == '0) begin
                                meas_en_q <= 1'b1;
                                state_q   <= S_MEASURE;
                            end else begin
                                state_q <= S_SETTLE;
                            end
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                    S_SETTLE: begin
                        if (cnt_q == settle_q - 1'b1) begin
                            cnt_q     <= '0;
                            meas_en_q <= 1'b1;
                            state_q   <= S_MEASURE;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                    S_MEASURE: begin
                        if (cnt_q == meas_last_q) begin
                            cnt_q       <= '0;
                            meas_en_q   <= 1'b0;
                            res_valid_q <= 1'b1;
                            state_q     <= S_REPORT;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                    S_REPORT: begin
                        if (res_ready) begin
                            res_valid_q <= 1'b0;
                            emu_rst_q   <= 1'b1;
                            // RX is the inner loop; bounds are checked before incrementing.
                            if (rx_setting_q == rx_max_q && tx_setting_q == tx_max_q) begin
                                busy_q  <= 1'b0;
                                done_q  <= 1'b1;
                                state_q <= S_IDLE;
                            end else if (rx_setting_q == rx_max_q) begin
                                rx_setting_q <= rx_min_q;
                                tx_setting_q <= tx_setting_q + 1'b1;
                                state_q      <= S_RESET;
                            end else begin
                                rx_setting_q <= rx_setting_q + 1'b1;
                                state_q      <= S_RESET;
                            end
                        end
                    end
                    default: begin
                        state_q   <= S_IDLE;
                        emu_rst_q <= 1'b1;
                        busy_q    <= 1'b0;
                    end
                endcase
            end
        end
    end

    // Clearing throughout RESET guarantees fresh counts when MEASURE begins.
    sat_err_counter #(
        .ERR_WIDTH(ERR_WIDTH)
    ) u_counter (
        .clk_i      (clk),
        .rst_i      (rst),
        .clr_i      (state_q == S_RESET),
        .en_i       (meas_en_q),
        .bit_valid_i(bit_valid),
        .bit_err_i  (bit_err),
        .bits_o     (acc_bits),
        .errs_o     (acc_errs)
    );

    always_comb begin
        result      = '0;
        result.tx   = tx_setting_q;
        result.rx   = rx_setting_q;
        result.bits = RES_COUNT_WIDTH'(acc_bits);
        result.errs = RES_COUNT_WIDTH'(acc_errs);
    end

    assign tx_setting = tx_setting_q;
    assign rx_setting = rx_setting_q;
    assign emu_rst    = emu_rst_q;
    assign meas_en    = meas_en_q;
    assign res_valid  = res_valid_q;
    assign res_tx     = result.tx;
    assign res_rx     = result.rx;
    assign res_bits   = ERR_WIDTH'(result.bits);
    assign res_errs   = ERR_WIDTH'(result.errs);
    assign busy       = busy_q;
    assign done       = done_q;
    assign cfg_err    = cfg_err_q;

endmodule

// File: tb/tb_link_sweep_ctrl.sv
// Directed bench for link_sweep_ctrl: grid order, timing, saturation, back-pressure,
// bound errors, abort and asynchronous reset.
module tb_link_sweep_ctrl;

    import tx_package::*;
    import filter_package::*;

    localparam int TXW = TX_SETTING_WIDTH;
    localparam int RXW = RX_SETTING_WIDTH;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            start = 1'b0;
    logic            abort = 1'b0;
    logic [TXW-1:0]  tx_min = '0, tx_max = '0;
    logic [RXW-1:0]  rx_min = '0, rx_max = '0;
    logic [31:0]     settle_cycles = '0, meas_cycles = '0;
    logic            bit_valid = 1'b1;
    logic            bit_err = 1'b0;
    logic            res_ready = 1'b1;

    logic [TXW-1:0]  tx_setting, res_tx, tx_setting4, res_tx4;
    logic [RXW-1:0]  rx_setting, res_rx, rx_setting4, res_rx4;
    logic            emu_rst, meas_en, res_valid, busy, done, cfg_err;
    logic            emu_rst4, meas_en4, res_valid4, busy4, done4, cfg_err4;
    logic [31:0]     res_bits, res_errs;
    logic [3:0]      res_bits4, res_errs4;

    int checks = 0;
    int errors = 0;
    int tickCount = 0;
    int totalDone = 0;
    int startTick = 0;
    bit errMode = 1'b0;

    int     nRes, firstMeasTick, doneTick;
    int     resTx[8], resRx[8], resTick[8];
    longint resBits[8], resErrs[8], resBits4[8], resErrs4[8];

    always #5 clk = ~clk;

    link_sweep_ctrl #(.RST_CYCLES(16), .CNT_WIDTH(32), .ERR_WIDTH(32)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .tx_min(tx_min), .tx_max(tx_max), .rx_min(rx_min), .rx_max(rx_max),
        .settle_cycles(settle_cycles), .meas_cycles(meas_cycles),
        .bit_valid(bit_valid), .bit_err(bit_err), .res_ready(res_ready),
        .tx_setting(tx_setting), .rx_setting(rx_setting), .emu_rst(emu_rst),
        .meas_en(meas_en), .res_valid(res_valid), .res_tx(res_tx), .res_rx(res_rx),
        .res_bits(res_bits), .res_errs(res_errs), .busy(busy), .done(done),
        .cfg_err(cfg_err)
    );

    // Narrow-counter copy sharing every input, used to observe saturation.
    link_sweep_ctrl #(.RST_CYCLES(16), .CNT_WIDTH(32), .ERR_WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .tx_min(tx_min), .tx_max(tx_max), .rx_min(rx_min), .rx_max(rx_max),
        .settle_cycles(settle_cycles), .meas_cycles(meas_cycles),
        .bit_valid(bit_valid), .bit_err(bit_err), .res_ready(res_ready),
        .tx_setting(tx_setting4), .rx_setting(rx_setting4), .emu_rst(emu_rst4),
        .meas_en(meas_en4), .res_valid(res_valid4), .res_tx(res_tx4), .res_rx(res_rx4),
        .res_bits(res_bits4), .res_errs(res_errs4), .busy(busy4), .done(done4),
        .cfg_err(cfg_err4)
    );

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, observed, expected);
        end
    endtask

    // All stimulus changes and observations happen at the falling edge.
    task automatic tick();
        @(negedge clk);
        tickCount++;
        if (done) totalDone++;
        if (errMode) bit_err = (tickCount % 4 == 0);
    endtask

    task automatic applyStimulus(input int txMin, input int txMax, input int rxMin,
                                 input int rxMax, input int settle, input int meas);
        tx_min        = TXW'(txMin);
        tx_max        = TXW'(txMax);
        rx_min        = RXW'(rxMin);
        rx_max        = RXW'(rxMax);
        settle_cycles = 32'(settle);
        meas_cycles   = 32'(meas);
        start         = 1'b1;
        startTick     = tickCount;
        tick();
        start = 1'b0;
    endtask

    task automatic runSweep(input int budget);
        nRes = 0;
        firstMeasTick = -1;
        doneTick = -1;
        for (int i = 0; i < budget; i++) begin
            if (meas_en && firstMeasTick < 0) firstMeasTick = tickCount;
            if (res_valid && res_ready && nRes < 8) begin
                resTx[nRes]    = int'(res_tx);
                resRx[nRes]    = int'(res_rx);
                resBits[nRes]  = longint'(res_bits);
                resErrs[nRes]  = longint'(res_errs);
                resBits4[nRes] = longint'(res_bits4);
                resErrs4[nRes] = longint'(res_errs4);
                resTick[nRes]  = tickCount;
                nRes++;
            end
            if (done) begin
                doneTick = tickCount;
                break;
            end
            tick();
        end
        if (doneTick < 0) checkOutput("sweep_timeout", 0, 1);
    endtask

    task automatic waitFor(input string tag, input int budget, input bit wantValid);
        int n = 0;
        while (((wantValid && !res_valid) || (!wantValid && !meas_en)) && n < budget) begin
            tick();
            n++;
        end
        if (n >= budget) checkOutput(tag, 0, 1);
    endtask

    initial begin
        int doneBefore;
        int expTx[4];
        int expRx[4];
        bit stable;
        logic [TXW-1:0] snapTx;
        logic [RXW-1:0] snapRx;
        logic [31:0] snapBits;

        expTx = '{2, 2, 3, 3};
        expRx = '{4, 5, 4, 5};

        tick();
        tick();
        checkOutput("rst_emu_rst", emu_rst, 1);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_res_valid", res_valid, 0);
        checkOutput("rst_tx_setting", tx_setting, 0);
        checkOutput("rst_cfg_err", cfg_err, 0);
        rst = 1'b0;
        tick();

        // Full 2x2 grid with ready tied high.
        doneBefore = totalDone;
        applyStimulus(2, 3, 4, 5, 10, 100);
        runSweep(1000);
        checkOutput("grid_count", nRes, 4);
        for (int i = 0; i < 4; i++) begin
            checkOutput($sformatf("grid_tx%0d", i), resTx[i], expTx[i]);
            checkOutput($sformatf("grid_rx%0d", i), resRx[i], expRx[i]);
            checkOutput($sformatf("grid_bits%0d", i), resBits[i], 100);
            checkOutput($sformatf("grid_errs%0d", i), resErrs[i], 0);
        end
        checkOutput("grid_first_meas", firstMeasTick - startTick, 27);
        checkOutput("grid_first_valid", resTick[0] - startTick, 127);
        checkOutput("grid_period", resTick[1] - resTick[0], 127);
        checkOutput("grid_done_tick", doneTick - startTick, 509);
        tick();
        checkOutput("grid_done_pulse", done, 0);
        checkOutput("grid_done_count", totalDone - doneBefore, 1);
        checkOutput("grid_idle_emu_rst", emu_rst, 1);

        // Single point, every 4th bit in error.
        errMode = 1'b1;
        applyStimulus(0, 0, 7, 7, 3, 40);
        runSweep(300);
        errMode = 1'b0;
        bit_err = 1'b0;
        checkOutput("pat_count", nRes, 1);
        checkOutput("pat_point", {resTx[0][7:0], resRx[0][7:0]}, {8'd0, 8'd7});
        checkOutput("pat_bits", resBits[0], 40);
        checkOutput("pat_errs", resErrs[0], 10);
        checkOutput("pat_done_follows", doneTick - resTick[0], 1);

        // All bits erroneous: wide counters count, narrow ones saturate.
        bit_err = 1'b1;
        applyStimulus(0, 0, 0, 0, 0, 50);
        runSweep(300);
        bit_err = 1'b0;
        checkOutput("sat_wide_bits", resBits[0], 50);
        checkOutput("sat_wide_errs", resErrs[0], 50);
        checkOutput("sat_narrow_bits", resBits4[0], 15);
        checkOutput("sat_narrow_errs", resErrs4[0], 15);

        // Back-pressure with a zero settle and zero measure window.
        res_ready = 1'b0;
        applyStimulus(1, 1, 0, 1, 0, 0);
        waitFor("bp_wait_valid", 100, 1'b1);
        checkOutput("bp_valid_tick", tickCount - startTick, 18);
        checkOutput("bp_bits_min_window", res_bits, 1);
        snapTx = res_tx;
        snapRx = res_rx;
        snapBits = res_bits;
        stable = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (res_tx !== snapTx || res_rx !== snapRx || res_bits !== snapBits ||
                res_valid !== 1'b1 || emu_rst !== 1'b0)
                stable = 1'b0;
        end
        checkOutput("bp_stable", stable, 1);
        res_ready = 1'b1;
        tick();
        checkOutput("bp_next_emu_rst", emu_rst, 1);
        checkOutput("bp_next_rx", rx_setting, 1);
        checkOutput("bp_next_valid", res_valid, 0);
        runSweep(200);
        checkOutput("bp_second_point", {resTx[0][7:0], resRx[0][7:0]}, {8'd1, 8'd1});

        // Bad bounds, then a valid start clears the error.
        doneBefore = totalDone;
        applyStimulus(0, 1, 5, 3, 2, 5);
        checkOutput("cfg_err_set", cfg_err, 1);
        checkOutput("cfg_busy", busy, 0);
        tick();
        tick();
        checkOutput("cfg_busy_later", busy, 0);
        checkOutput("cfg_no_done", totalDone - doneBefore, 0);
        applyStimulus(3, 4, 2, 3, 2, 20);
        checkOutput("cfg_err_clear", cfg_err, 0);
        checkOutput("cfg_valid_busy", busy, 1);

        // Abort mid-MEASURE.
        waitFor("abort_wait_meas", 100, 1'b0);
        tick();
        tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        checkOutput("abort_busy", busy, 0);
        checkOutput("abort_emu_rst", emu_rst, 1);
        checkOutput("abort_meas_en", meas_en, 0);
        checkOutput("abort_res_valid", res_valid, 0);
        checkOutput("abort_hold_tx", tx_setting, 3);
        tick();
        tick();
        checkOutput("abort_no_done", totalDone - doneBefore, 0);

        // Abort and start together: abort wins.
        abort = 1'b1;
        applyStimulus(0, 1, 0, 1, 0, 1);
        abort = 1'b0;
        checkOutput("abort_start_busy", busy, 0);

        // Restart from the min bounds; abort together with ready in REPORT.
        res_ready = 1'b0;
        applyStimulus(3, 4, 2, 3, 0, 2);
        checkOutput("restart_tx", tx_setting, 3);
        checkOutput("restart_rx", rx_setting, 2);
        waitFor("abort_wait_report", 100, 1'b1);
        res_ready = 1'b1;
        abort = 1'b1;
        tick();
        abort = 1'b0;
        checkOutput("abort_rep_busy", busy, 0);
        checkOutput("abort_rep_valid", res_valid, 0);
        checkOutput("abort_rep_rx_hold", rx_setting, 2);
        checkOutput("abort_rep_no_done", totalDone - doneBefore, 0);

        // Asynchronous reset mid-sweep forces emu_rst without a clock edge.
        applyStimulus(0, 1, 0, 1, 0, 30);
        waitFor("arst_wait_meas", 100, 1'b0);
        #2 rst = 1'b1;
        #1;
        checkOutput("arst_emu_rst", emu_rst, 1);
        checkOutput("arst_busy", busy, 0);
        checkOutput("arst_meas_en", meas_en, 0);
        tick();
        rst = 1'b0;
        tick();
        checkOutput("arst_tx_cleared", tx_setting, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/link_sweep_ctrl.md
# link_sweep_ctrl

Autonomous settings-sweep controller for the link emulator. It steps the TX FFE and RX CTLE settings through a rectangular grid. For each point it holds the emulator in reset, waits a settle window, then counts checked bits and bit errors over a measurement window. Each point's result is emitted on a valid/ready channel. It sits between the VIO/host configuration registers and the emulator's `tx_setting_ext`/`rx_setting_ext`/reset inputs, replacing manual per-setting runs.

## Interface
- `RST_CYCLES`, 16: emulator reset hold per point, in clk cycles (≥1).
- `CNT_WIDTH`, 32: width of settle/measure window counters.
- `ERR_WIDTH`, 32: width of bit and error counters.
- `clk  in  1`: system clock.
- `rst  in  1`: reset, asynchronous, active-high.
- `start  in  1`: pulse; begins a sweep when IDLE.
- `abort  in  1`: terminates a sweep from any state.
- `tx_min, tx_max  in  TX_SETTING_WIDTH`: TX sweep bounds, inclusive.
- `rx_min, rx_max  in  RX_SETTING_WIDTH`: RX sweep bounds, inclusive.
- `settle_cycles  in  CNT_WIDTH`: cycles after reset release before measuring.
- `meas_cycles  in  CNT_WIDTH`: measurement window length.
- `bit_valid  in  1`: checker produced a bit this cycle.
- `bit_err  in  1`: that bit mismatched; qualified by `bit_valid`.
- `res_ready  in  1`: result consumer ready.
- `tx_setting  out  TX_SETTING_WIDTH`: to emulator TX FFE.
- `rx_setting  out  RX_SETTING_WIDTH`: to emulator RX CTLE.
- `emu_rst  out  1`: emulator reset, active-high.
- `meas_en  out  1`: high during the measurement window.
- `res_valid  out  1`: result available.
- `res_tx, res_rx  out  TX/RX_SETTING_WIDTH`: grid point of the result.
- `res_bits, res_errs  out  ERR_WIDTH`: bits checked and errors counted.
- `busy  out  1`: state ≠ IDLE.
- `done  out  1`: one-cycle pulse when a sweep completes normally.
- `cfg_err  out  1`: sticky; a bound had min > max. Cleared by the next accepted `start`.

## Operation
- Reset values of all outputs are 0, except `emu_rst` = 1. Emulator is held in reset while idle.
- States: IDLE, RESET, SETTLE, MEASURE, REPORT.
- **IDLE**
  - `start` with `abort` low → latch all bound and window inputs and clear `cfg_err`.
  - If `tx_min > tx_max` or `rx_min > rx_max`: set `cfg_err`, stay IDLE, no `done`.
  - Otherwise: load `tx_setting = tx_min`, `rx_setting = rx_min`, go to RESET.
- **RESET**
  - `emu_rst` = 1 for exactly `RST_CYCLES` cycles.
  - Then → SETTLE, or → MEASURE if `settle_cycles == 0`.
- **SETTLE**
  - `emu_rst` = 0 for `settle_cycles` cycles, then → MEASURE.
- **MEASURE**
  - `meas_en` = 1 for `max(meas_cycles, 1)` cycles.
  - Bit/error counters clear on entry.
  - Each cycle: `bits += bit_valid`, `errs += bit_valid & bit_err`. Both saturate at all-ones; no wrap.
  - Then → REPORT.
- **REPORT**
  - `res_valid` = 1; all `res_*` stable until accepted.
  - Transfer occurs when `res_valid & res_ready`. On transfer:
    - If `rx_setting == rx_max` and `tx_setting == tx_max`: → IDLE, pulse `done`.
    - Else if `rx_setting == rx_max`: `rx_setting = rx_min`, `tx_setting + 1`, → RESET.
    - Else: `rx_setting + 1`, → RESET.
  - RX is the inner loop. No arithmetic wrap is possible because the bound check precedes any increment.
- `tx_setting`/`rx_setting` change only on the transition into RESET.
- `emu_rst` = 1 in IDLE and RESET, 0 elsewhere.
- `start` while busy is ignored. Bound inputs are not re-sampled mid-sweep.
- **abort**
  - From any state → IDLE on the next edge.
  - `res_valid` drops, no `done`, settings outputs hold their last value.
  - `abort` and `start` together in IDLE: abort wins.
  - `abort` in REPORT coincident with `res_ready`: no transfer counted.

## Timing
- Edge k, IDLE, `start` sampled → cycles k+1 … k+RST_CYCLES in RESET.
- First MEASURE cycle: k+1+RST_CYCLES+settle_cycles.
- `res_valid` rises the cycle after the last MEASURE cycle. It is registered, with no combinational path from `res_ready`.
- Transfer at edge j → next point's RESET begins at j+1. `done` is high at j+1 for the final point.
- Per-point period with `res_ready` tied high: RST_CYCLES + settle_cycles + max(meas_cycles,1) + 1.
- Async `rst` mid-sweep: all state lost immediately; `emu_rst` = 1 asynchronously.

## Structure
- `TX_SETTING_WIDTH` comes from `tx_package`; `RX_SETTING_WIDTH` from `filter_package`.
- New `sweep_package` holds: state enum `sweep_state_t`, default `CNT_WIDTH`/`ERR_WIDTH`, and a `sweep_result_t` struct {tx, rx, bits, errs}.
- One sub-module: `sat_err_counter`, a clear/enable saturating bits+errors accumulator, instanced once.

## Test plan
- tx 2..3, rx 4..5, settle 10, meas 100, `res_ready` = 1, `bit_valid` = 1, `bit_err` = 0 → four results in order (2,4),(2,5),(3,4),(3,5). Each has bits = 100, errs = 0. One `done` pulse; period 127 cycles with RST_CYCLES = 16.
- tx 0..0, rx 7..7, `bit_err` high every 4th valid bit, meas 40 → single result with bits = 40, errs = 10; `done` follows.
- `ERR_WIDTH` = 4, meas 50, all bits erroneous → bits = 15, errs = 15 (saturated).
- `res_ready` held low 20 cycles in REPORT → `res_*` stable and `emu_rst` stays 0; the next point starts the cycle after `res_ready` rises.
- `rx_min` = 5, `rx_max` = 3, `start` → `cfg_err` = 1, `busy` stays 0. A valid `start` afterwards clears `cfg_err`.
- `abort` mid-MEASURE, then `start` → IDLE the next cycle, `emu_rst` = 1, no `done`, no `res_valid`. The new sweep restarts from the min bounds.
